// File: rtl/step_pkg.sv
// rtl/step_pkg.sv - shared state encoding and default timing for the step sequencer
package step_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    localparam int DEF_PULSE_W    = 100;
    localparam int DEF_DIR_SETUP  = 250;
    localparam int DEF_PERIOD_MIN = 200;

    localparam logic DIR_POS = 1'b1;

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - loadable down-counter that parks at zero and flags done
module step_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - STEP/DIR pulse generator with driver timing and position count
module step_sequencer
    import step_pkg::*;
#(
    parameter int WIDTH_WORK = 16,
    parameter int POS_W      = 32,
    parameter int PULSE_W    = DEF_PULSE_W,
    parameter int DIR_SETUP  = DEF_DIR_SETUP,
    parameter int PERIOD_MIN = DEF_PERIOD_MIN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    dir_req,
    input  logic [WIDTH_WORK-1:0]   period,
    input  logic                    pos_clear,
    output logic                    step,
    output logic                    dir,
    output logic                    busy,
    output logic                    period_clamped,
    output logic signed [POS_W-1:0] position
);

    localparam int TIMER_MAX = (PULSE_W > DIR_SETUP) ? PULSE_W : DIR_SETUP;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

    // A pulse must end before the next period boundary, otherwise LOW is never reached.
    generate
        if (PERIOD_MIN <= PULSE_W) begin : g_bad_timing
            $error("step_sequencer: PERIOD_MIN must exceed PULSE_W");
        end
    endgenerate

    state_t                state, state_n;
    logic                  dir_n;
    logic                  run;
    logic                  enter_high;
    logic                  below_min;
    logic [WIDTH_WORK-1:0] p_eff;
    logic [WIDTH_WORK-1:0] per_val;
    logic                  tmr_load, tmr_done;
    logic [TIMER_W-1:0]    tmr_val;
    logic                  per_done;

    assign run       = enable && (period != '0);
    assign below_min = (period < WIDTH_WORK'(PERIOD_MIN));
    assign p_eff     = below_min ? WIDTH_WORK'(PERIOD_MIN) : period;
    assign per_val   = p_eff - WIDTH_WORK'(1);

    // Shared by pulse-width and direction-setup timing; the two never overlap.
    step_timer #(.W(TIMER_W)) u_pulse_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_val),
        .done  (tmr_done)
    );

    // Loaded with P-1 at each rising edge so the next rise lands exactly P cycles later.
    step_timer #(.W(WIDTH_WORK)) u_period_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (enter_high),
        .value (per_val),
        .done  (per_done)
    );

    always_comb begin
        state_n    = state;
        dir_n      = dir;
        enter_high = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        unique case (state)
            IDLE: begin
                if (run) begin
                    if (dir_req != dir) begin
                        dir_n    = dir_req;
                        state_n  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = TIMER_W'(DIR_SETUP - 1);
                    end else begin
                        enter_high = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (!run) begin
                    state_n = IDLE;
                end else if (tmr_done) begin
                    enter_high = 1'b1;
                end
            end
            HIGH: begin
                if (tmr_done) begin
                    state_n = LOW;
                end
            end
            LOW: begin
                if (per_done) begin
                    if (!run) begin
                        state_n = IDLE;
                    end else if (dir_req != dir) begin
                        dir_n    = dir_req;
                        state_n  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = TIMER_W'(DIR_SETUP - 1);
                    end else begin
                        enter_high = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (enter_high) begin
            state_n  = HIGH;
            tmr_load = 1'b1;
            tmr_val  = TIMER_W'(PULSE_W - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            dir            <= 1'b0;
            step           <= 1'b0;
            busy           <= 1'b0;
            period_clamped <= 1'b0;
            position       <= '0;
        end else begin
            state <= state_n;
            dir   <= dir_n;
            step  <= (state_n == HIGH);
            busy  <= (state_n != IDLE);
            if (enter_high) begin
                period_clamped <= below_min;
            end
            if (pos_clear) begin
                position <= '0;
            end else if (enter_high) begin
                position <= (dir == DIR_POS) ? position + POS_ONE : position - POS_ONE;
            end
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - self-checking bench for step_sequencer
module tb_step_sequencer;

    localparam int POS_W = 8;
    localparam int PW    = 100;
    localparam int DS    = 250;
    localparam int PMIN  = 200;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    enable = 1'b0;
    logic                    dir_req = 1'b0;
    logic [15:0]             period = '0;
    logic                    pos_clear = 1'b0;
    logic                    step, dir, busy, period_clamped;
    logic signed [POS_W-1:0] position;

    int cyc = 0;
    int tests_run = 0;
    int fails = 0;

    step_sequencer #(.WIDTH_WORK(16), .POS_W(POS_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .dir_req        (dir_req),
        .period         (period),
        .pos_clear      (pos_clear),
        .step           (step),
        .dir            (dir),
        .busy           (busy),
        .period_clamped (period_clamped),
        .position       (position)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rise(input int budget, output int t, output bit ok);
        bit prev;
        prev = step;
        ok = 1'b0;
        t = cyc;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (step && !prev) begin
                ok = 1'b1;
                t = cyc;
                return;
            end
            prev = step;
        end
        t = cyc;
    endtask

    task automatic wait_fall(input int budget, output int t, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!step) begin
                ok = 1'b1;
                t = cyc;
                return;
            end
        end
        t = cyc;
    endtask

    task automatic stop_and_idle(output bit ok);
        enable = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic clear_pos();
        pos_clear = 1'b1;
        @(negedge clk);
        pos_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycles(2);
        tests_run++; if (step !== 1'b0) begin fails++; $display("FAIL reset_step: got %b want 0", step); end
        tests_run++; if (dir !== 1'b0) begin fails++; $display("FAIL reset_dir: got %b want 0", dir); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (period_clamped !== 1'b0) begin fails++; $display("FAIL reset_clamped: got %b want 0", period_clamped); end
        tests_run++; if (position !== '0) begin fails++; $display("FAIL reset_position: got %0d want 0", position); end
        rst = 1'b0;
        cycles(2);
    endtask

    task automatic test_basic();
        int r, t;
        bit ok;
        enable = 1'b1; dir_req = 1'b0; period = 16'd1000;
        @(negedge clk);
        r = cyc;
        tests_run++; if (step !== 1'b1) begin fails++; $display("FAIL basic_latency: step=%b want 1", step); end
        wait_fall(500, t, ok);
        tests_run++; if (!ok || t - r != PW) begin fails++; $display("FAIL basic_width: got %0d want %0d", t - r, PW); end
        for (int k = 1; k < 5; k++) begin
            wait_rise(2000, t, ok);
            tests_run++; if (!ok || t - r != 1000) begin fails++; $display("FAIL basic_period%0d: got %0d want 1000", k, t - r); end
            r = t;
        end
        tests_run++; if (position !== POS_W'(-5)) begin fails++; $display("FAIL basic_position: got %0d want -5", position); end
        tests_run++; if (period_clamped !== 1'b0) begin fails++; $display("FAIL basic_clamped: got %b want 0", period_clamped); end
        stop_and_idle(ok);
        tests_run++; if (!ok) begin fails++; $display("FAIL basic_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_clamp();
        int r, t;
        bit ok;
        clear_pos();
        enable = 1'b1; dir_req = 1'b0; period = 16'd50;
        @(negedge clk);
        r = cyc;
        wait_rise(2000, t, ok);
        tests_run++; if (!ok || t - r != PMIN) begin fails++; $display("FAIL clamp_period: got %0d want %0d", t - r, PMIN); end
        tests_run++; if (period_clamped !== 1'b1) begin fails++; $display("FAIL clamp_flag: got %b want 1", period_clamped); end
        r = t;
        period = 16'd600;
        wait_rise(2000, t, ok);
        tests_run++; if (!ok || t - r != PMIN) begin fails++; $display("FAIL clamp_old_period: got %0d want %0d", t - r, PMIN); end
        tests_run++; if (period_clamped !== 1'b0) begin fails++; $display("FAIL clamp_flag_clear: got %b want 0", period_clamped); end
        r = t;
        wait_rise(2000, t, ok);
        tests_run++; if (!ok || t - r != 600) begin fails++; $display("FAIL clamp_new_period: got %0d want 600", t - r); end
        tests_run++; if (position !== POS_W'(-4)) begin fails++; $display("FAIL clamp_position: got %0d want -4", position); end
        stop_and_idle(ok);
        tests_run++; if (!ok) begin fails++; $display("FAIL clamp_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_reverse();
        int r0, t;
        bit ok;
        clear_pos();
        enable = 1'b1; dir_req = 1'b0; period = 16'd1000;
        @(negedge clk);
        r0 = cyc;
        cycles(300);
        dir_req = 1'b1;
        ok = 1'b0;
        t = cyc;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (dir) begin ok = 1'b1; t = cyc; end
        end
        tests_run++; if (!ok || t - r0 != 1000) begin fails++; $display("FAIL reverse_dir_flip: at %0d want 1000", t - r0); end
        tests_run++; if (step !== 1'b0) begin fails++; $display("FAIL reverse_step_at_flip: got %b want 0", step); end
        wait_rise(2000, t, ok);
        tests_run++; if (!ok || t - r0 != 1000 + DS) begin fails++; $display("FAIL reverse_rise: at %0d want %0d", t - r0, 1000 + DS); end
        tests_run++; if (position !== POS_W'(0)) begin fails++; $display("FAIL reverse_position: got %0d want 0", position); end
        r0 = t;
        wait_rise(2000, t, ok);
        tests_run++; if (!ok || t - r0 != 1000 || position !== POS_W'(1)) begin fails++; $display("FAIL reverse_next: interval %0d pos %0d want 1000 and 1", t - r0, position); end
        stop_and_idle(ok);
        tests_run++; if (!ok) begin fails++; $display("FAIL reverse_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_enable_drop();
        int r0, t;
        bit ok;
        clear_pos();
        enable = 1'b1; dir_req = 1'b1; period = 16'd1000;
        @(negedge clk);
        r0 = cyc;
        cycles(30);
        enable = 1'b0;
        wait_fall(500, t, ok);
        tests_run++; if (!ok || t - r0 != PW) begin fails++; $display("FAIL drop_width: got %0d want %0d", t - r0, PW); end
        cycles(r0 + 999 - cyc);
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL drop_busy_in_period: got %b want 1", busy); end
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL drop_busy_after: got %b want 0", busy); end
        wait_rise(2000, t, ok);
        tests_run++; if (ok) begin fails++; $display("FAIL drop_no_pulse: rise at %0d want none", t - r0); end
        tests_run++; if (position !== POS_W'(1)) begin fails++; $display("FAIL drop_position: got %0d want 1", position); end
    endtask

    task automatic test_async_reset();
        int c, t;
        bit ok;
        enable = 1'b1; dir_req = 1'b1; period = 16'd1000;
        @(negedge clk);
        tests_run++; if (step !== 1'b1) begin fails++; $display("FAIL areset_start: step=%b want 1", step); end
        cycles(20);
        #3;
        rst = 1'b1;
        #1;
        tests_run++; if (step !== 1'b0 || busy !== 1'b0 || position !== '0 || dir !== 1'b0) begin fails++; $display("FAIL areset_immediate: step=%b busy=%b pos=%0d dir=%b want 0", step, busy, position, dir); end
        cycles(4);
        tests_run++; if (step !== 1'b0) begin fails++; $display("FAIL areset_hold: step=%b want 0", step); end
        rst = 1'b0;
        c = cyc;
        wait_rise(1000, t, ok);
        tests_run++; if (!ok || t - c != 1 + DS) begin fails++; $display("FAIL areset_restart: got %0d want %0d", t - c, 1 + DS); end
        tests_run++; if (position !== POS_W'(1) || dir !== 1'b1) begin fails++; $display("FAIL areset_pos: pos=%0d dir=%b want 1 1", position, dir); end
        stop_and_idle(ok);
    endtask

    task automatic test_pos_clear_wrap();
        int r, t;
        bit ok, all_ok;
        clear_pos();
        enable = 1'b1; dir_req = 1'b1; period = 16'd200;
        @(negedge clk);
        r = cyc;
        for (int k = 0; k < 6; k++) wait_rise(1000, r, ok);
        tests_run++; if (position !== POS_W'(7)) begin fails++; $display("FAIL clear_pre: got %0d want 7", position); end
        cycles(r + 199 - cyc);
        pos_clear = 1'b1;
        @(negedge clk);
        pos_clear = 1'b0;
        tests_run++; if (step !== 1'b1 || position !== '0) begin fails++; $display("FAIL clear_coincident: step=%b pos=%0d want 1 0", step, position); end
        wait_rise(1000, t, ok);
        tests_run++; if (!ok || position !== POS_W'(1)) begin fails++; $display("FAIL clear_next: pos=%0d want 1", position); end
        all_ok = 1'b1;
        for (int k = 0; k < 126; k++) begin
            wait_rise(1000, t, ok);
            all_ok &= ok;
        end
        tests_run++; if (!all_ok || position !== POS_W'(127)) begin fails++; $display("FAIL wrap_max: pos=%0d want 127", position); end
        wait_rise(1000, t, ok);
        tests_run++; if (!ok || position !== POS_W'(-128)) begin fails++; $display("FAIL wrap_min: pos=%0d want -128", position); end
        stop_and_idle(ok);
    endtask

    task automatic test_random();
        int c, r, t, p, exp_pos, cur_p, want;
        bit d, exp_dir, ok;
        clear_pos();
        exp_pos = 0;
        exp_dir = dir;
        p = $urandom_range(600, 1);
        d = 1'($urandom_range(1, 0));
        enable = 1'b1; period = 16'(p); dir_req = d;
        c = cyc;
        wait_rise(1000, t, ok);
        want = 1 + ((d != exp_dir) ? DS : 0);
        tests_run++; if (!ok || t - c != want) begin fails++; $display("FAIL rand_first: got %0d want %0d", t - c, want); end
        exp_dir = d;
        exp_pos += exp_dir ? 1 : -1;
        cur_p = (p < PMIN) ? PMIN : p;
        for (int i = 0; i < 16; i++) begin
            r = t;
            p = $urandom_range(600, 1);
            d = 1'($urandom_range(1, 0));
            period = 16'(p); dir_req = d;
            wait_fall(500, t, ok);
            tests_run++; if (!ok || t - r != PW) begin fails++; $display("FAIL rand_width%0d: got %0d want %0d", i, t - r, PW); end
            wait_rise(2000, t, ok);
            want = cur_p + ((d != exp_dir) ? DS : 0);
            tests_run++; if (!ok || t - r != want) begin fails++; $display("FAIL rand_interval%0d: got %0d want %0d", i, t - r, want); end
            exp_dir = d;
            exp_pos += exp_dir ? 1 : -1;
            cur_p = (p < PMIN) ? PMIN : p;
            tests_run++; if (position !== POS_W'(exp_pos) || dir !== exp_dir || period_clamped !== (p < PMIN)) begin fails++; $display("FAIL rand_state%0d: pos=%0d dir=%b clamp=%b want %0d %b %b", i, position, dir, period_clamped, exp_pos, exp_dir, p < PMIN); end
        end
        stop_and_idle(ok);
        tests_run++; if (!ok) begin fails++; $display("FAIL rand_idle: busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_reverse();
        test_enable_drop();
        test_async_reset();
        test_pos_clear_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
Converts the tracking loop's per-step period N, direction request and motor-enable into a clean STEP/DIR pulse train for the stepper driver.
- Enforces driver timing: minimum pulse width, direction setup before the first step after a reversal, and a minimum step period.
- Keeps a signed step position counter.
- Sits between the tracking-mode controller (N, drv_dir, drv_enable_SM) and the driver pins.

Parameters:
WIDTH_WORK, 16, width of the period input and period counter
POS_W, 32, width of the signed position counter
PULSE_W, 100, STEP high time in clk cycles (2 us at 50 MHz)
DIR_SETUP, 250, cycles DIR must be stable before a STEP rising edge after a direction change
PERIOD_MIN, 200, minimum step period in cycles; must be > PULSE_W (elaboration-time check)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset; clock clk, asynchronous, active-high
enable  in  1  motion enable from tracking controller
dir_req  in  1  requested direction (1 = position increments)
period  in  WIDTH_WORK  requested step period in clk cycles; 0 = stop
pos_clear  in  1  synchronous clear of position counter
step  out  1  STEP pin
dir  out  1  DIR pin
busy  out  1  high in any state other than IDLE
period_clamped  out  1  latched period was raised to PERIOD_MIN
position  out  POS_W  signed step count

Behaviour:
- Reset values: step=0, dir=0, busy=0, period_clamped=0, position=0, state IDLE, all counters 0.
- Async reset acts immediately, including mid-pulse.
- States: IDLE, SETUP, HIGH, LOW.
- IDLE:
  - Leaves only when enable=1 and period!=0.
  - If dir_req!=dir: dir<=dir_req, go to SETUP.
  - Otherwise go to HIGH.
  - Latency: step=1 on the first clk edge after the condition is sampled.
- Period latch: on every entry to HIGH, P <= max(period, PERIOD_MIN); period_clamped <= (period<PERIOD_MIN).
- SETUP:
  - Counts DIR_SETUP cycles, then goes to HIGH.
  - If enable=0 or period=0 during SETUP, return to IDLE; dir keeps its new value.
- HIGH:
  - step=1 for exactly PULSE_W cycles.
  - Period counter starts at the rising edge, counting 0..P-1.
  - position <= position+1 if dir=1, else -1, on the rising-edge cycle.
  - enable=0 never truncates a pulse.
- LOW:
  - step=0 until the period counter reaches P-1, so rising edges are exactly P cycles apart.
  - Then, if enable=0 or period=0: IDLE.
  - Else if dir_req!=dir: dir<=dir_req, go to SETUP. The next rise is then P+DIR_SETUP after the previous rise.
  - Else HIGH, latching the new P.
- period changes take effect only at the next period boundary. dir_req changes are sampled only in IDLE and at the LOW exit, so dir never changes while step=1 or inside a period.
- position wraps modulo 2^POS_W (two's complement).
- pos_clear has priority over a simultaneous step update: position=0, and that step is not counted.
- Counter widths: period counter WIDTH_WORK bits; timer wide enough for max(PULSE_W, DIR_SETUP).

Decomposition:
- Shared package step_pkg holds:
  - state enum (IDLE/SETUP/HIGH/LOW);
  - default timing constants PULSE_W, DIR_SETUP, PERIOD_MIN;
  - DIR_POS=1 encoding.
- One sub-module, step_timer: loadable down-counter with a done flag. Instanced twice: pulse/setup timer and period timer.

Test Plan:
1. enable=1, dir_req=0, period=1000 after reset.
   - step rises 1 cycle later and stays high 100 cycles.
   - Rises every 1000 cycles; after 5 pulses position=-5, period_clamped=0.
2. period=50, dir_req=0.
   - Rises every 200 cycles, period_clamped=1.
   - Change to period=600: next period (after current completes) is 600, clamped=0.
3. Running at period=1000, dir=0; dir_req->1 at cycle 300 after a rise.
   - dir flips at cycle 1000, next rise at cycle 1250.
   - position then increments.
4. enable->0 at cycle 30 of HIGH.
   - step stays high through cycle 100; LOW until period end, then IDLE with busy=0.
   - No further pulses.
5. rst asserted mid-HIGH between clk edges.
   - step=0, position=0, busy=0 immediately; no pulse until rst=0 and enable=1.
6. Coincident checks:
   - pos_clear on a rising-edge cycle with position=7: position=0, next pulse yields ±1.
   - position=2^31-1 with dir=1: wraps to -2^31.
